hmcs_key_matrix: RTL and testbench

//   Input-side companion to the HMCS44A core. Debounces a raw NCOLS x NROWS key matrix and two

---
 rtl/hmcs_key_matrix.sv | 116 +++++++++++
 tb/tb_hmcs_key_matrix.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmcs_key_matrix.sv
// hmcs_key_matrix
// Input-side companion to the HMCS44A core. It debounces a raw key matrix
// and two interrupt keys, then returns the rows of the columns the MCU is
// strobing on its D port as R0 input data.
//
// All debouncing runs on a slow sample tick taken from a free-running
// divider. A key changes its debounced level only after DB_COUNT consecutive
// ticks that all disagree with the current level. A single agreeing sample
// restarts that count. The row return is a plain registered OR-reduction. It
// runs on every clock, so a strobe change is visible to the MCU one cycle
// later.

module hmcs_key_matrix #(
  parameter int NCOLS    = 16,
  parameter int NROWS    = 4,
  parameter int DIV      = 4,
  parameter int DB_COUNT = 3,
  parameter int INVERT   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCOLS*NROWS-1:0] i_keys,
  input  logic [1:0]             i_int_keys,
  input  logic [NCOLS-1:0]       i_D,
  output logic [NROWS-1:0]       o_R,
  output logic                   o_int0,
  output logic                   o_int1,
  output logic [NCOLS*NROWS-1:0] o_keys
);

  // Matrix keys occupy the low indices. The two interrupt keys sit on top,
  // so one debounce loop covers every input.
  localparam int NKEYS = NCOLS * NROWS;
  localparam int NIN   = NKEYS + 2;

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(DB_COUNT) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [NIN-1:0]   raw;
  logic [NIN-1:0]   db;
  logic [CNT_W-1:0] cnt [NIN];
  logic [NROWS-1:0] rows;

  assign tick = (div == DIV_LAST);
  assign raw  = {i_int_keys, i_keys};

  // Sample divider: count 0..DIV-1 and flag the last count as the tick.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Per-input debounce: accept a new level after DB_COUNT differing ticks.
  // NOTE: the counter array is reset explicitly. A reset that lands in the
  // middle of a press must discard the partial count, so leaving this storage
  // unreset would cause early acceptance after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int k = 0; k < NIN; k++) begin
        cnt[k] <= '0;
      end
    end else if (tick) begin
      for (int k = 0; k < NIN; k++) begin
        if (raw[k] == db[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_LAST) begin
          db[k]  <= raw[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Row selection: OR together the debounced rows of every strobed column.
  // NOTE: rows gets a default before the loop. Without it, a column that is
  // never strobed would leave rows unassigned on that path and infer a latch.
  always_comb begin
    rows = '0;
    for (int c = 0; c < NCOLS; c++) begin
      if (i_D[c]) begin
        rows = rows | db[c*NROWS +: NROWS];
      end
    end
  end

  // Row return register: updated on every clock, polarity chosen by INVERT.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_R <= (INVERT != 0) ? '1 : '0;
    end else begin
      o_R <= (INVERT != 0) ? ~rows : rows;
    end
  end

  // The debounce flops already register these outputs, so they drive the
  // MCU pins directly with no extra stage.
  assign o_keys = db[NKEYS-1:0];
  assign o_int0 = db[NKEYS];
  assign o_int1 = db[NKEYS+1];

endmodule

// File: tb/tb_hmcs_key_matrix.sv
// tb_hmcs_key_matrix
// Directed scenarios with timing derived from the debounce rules, followed by
// a randomized run compared against a sliding-window reference model.

module tb_hmcs_key_matrix;

  localparam int NCOLS = 16;
  localparam int NROWS = 4;
  localparam int NK    = NCOLS * NROWS;
  localparam int NIN   = NK + 2;
  localparam int DIV   = 4;
  localparam int DB    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] i_keys;
  logic [1:0]    i_int_keys;
  logic [15:0]   i_D;
  logic [3:0]    o_R;
  logic          o_int0;
  logic          o_int1;
  logic [NK-1:0] o_keys;

  int n_checks = 0;
  int n_pass   = 0;

  hmcs_key_matrix #(
    .NCOLS(NCOLS), .NROWS(NROWS), .DIV(DIV), .DB_COUNT(DB), .INVERT(0)
  ) dut (
    .clk(clk), .reset(reset), .i_keys(i_keys), .i_int_keys(i_int_keys),
    .i_D(i_D), .o_R(o_R), .o_int0(o_int0), .o_int1(o_int1), .o_keys(o_keys)
  );

  always #5 clk = ~clk;

  // Reference model. A key flips when its last DB tick samples all disagree
  // with its current level. Ticks fall on every DIV-th edge after reset.
  logic [NIN-1:0] m_deb;
  bit             m_hist [NIN][DB];
  int             m_nval [NIN];
  int             m_edges;
  logic [3:0]     m_R;

  task automatic model_step();
    logic [NIN-1:0] raw;
    logic [3:0]     rw;
    bit             all_diff;
    raw = {i_int_keys, i_keys};
    if (reset) begin
      m_edges = 0;
      m_deb   = '0;
      m_R     = '0;
      for (int k = 0; k < NIN; k++) m_nval[k] = 0;
    end else begin
      rw = '0;
      for (int c = 0; c < NCOLS; c++)
        if (i_D[c]) rw = rw | m_deb[c*NROWS +: NROWS];
      m_R = rw;
      m_edges++;
      if (m_edges % DIV == 0) begin
        for (int k = 0; k < NIN; k++) begin
          for (int j = DB - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
          m_hist[k][0] = raw[k];
          if (m_nval[k] < DB) m_nval[k]++;
          all_diff = (m_nval[k] >= DB);
          for (int j = 0; j < DB; j++)
            if (m_hist[k][j] == m_deb[k]) all_diff = 0;
          if (all_diff) m_deb[k] = raw[k];
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Holds reset for n clocks, then releases it at a negedge. The next posedge
  // is edge 1 after release.
  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_keys = '1; i_int_keys = 2'b11; i_D = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_R, o_keys, o_int0, o_int1} !== '0)
        $display("FAIL reset_outputs: got o_R=%b o_keys=%h int=%b%b want all 0",
                 o_R, o_keys, o_int1, o_int0);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    logic [NK-1:0] exp_k;
    exp_k = '0; exp_k[9] = 1'b1;
    i_keys = exp_k; i_int_keys = '0; i_D = 16'h0004; reset = 1'b0;
    repeat (11) @(negedge clk);
    n_checks++;
    if (o_keys !== '0 || o_R !== 4'b0000)
      $display("FAIL press_edge11: got o_keys=%h o_R=%b want 0/0000", o_keys, o_R);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_keys !== exp_k || o_R !== 4'b0000)
      $display("FAIL press_edge12: got o_keys=%h o_R=%b want %h/0000", o_keys, o_R, exp_k);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_R !== 4'b0010)
      $display("FAIL press_edge13: got o_R=%b want 0010", o_R);
    else n_pass++;
    i_keys = '0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (o_keys !== exp_k || o_R !== 4'b0010)
      $display("FAIL release_edge23: got o_keys=%h o_R=%b want %h/0010", o_keys, o_R, exp_k);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_keys !== '0 || o_R !== 4'b0010)
      $display("FAIL release_edge24: got o_keys=%h o_R=%b want 0/0010", o_keys, o_R);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_R !== 4'b0000)
      $display("FAIL release_edge25: got o_R=%b want 0000", o_R);
    else n_pass++;
  endtask

  task automatic test_glitch();
    i_keys = '0; i_int_keys = '0; i_D = '0;
    apply_reset(1);
    i_keys[0] = 1'b1;
    repeat (8) @(negedge clk);
    i_keys[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_keys !== '0)
        $display("FAIL glitch_reject: got o_keys=%h want 0", o_keys);
      else n_pass++;
    end
    i_keys[0] = 1'b1;
    repeat (11) @(negedge clk);
    n_checks++;
    if (o_keys !== '0)
      $display("FAIL glitch_repress_early: got o_keys=%h want 0", o_keys);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_keys !== 64'h1)
      $display("FAIL glitch_repress_accept: got o_keys=%h want %h", o_keys, 64'h1);
    else n_pass++;
  endtask

  task automatic test_multi_strobe();
    i_keys[23] = 1'b1; i_D = '0;
    repeat (16) @(negedge clk);
    n_checks++;
    if (o_keys !== 64'h0080_0001 || o_R !== 4'b0000)
      $display("FAIL strobe_setup: got o_keys=%h o_R=%b want %h/0000", o_keys, o_R, 64'h0080_0001);
    else n_pass++;
    i_D = 16'h0021;
    @(negedge clk);
    n_checks++;
    if (o_R !== 4'b1001) $display("FAIL strobe_0021: got o_R=%b want 1001", o_R);
    else n_pass++;
    i_D = 16'h0001;
    @(negedge clk);
    n_checks++;
    if (o_R !== 4'b0001) $display("FAIL strobe_0001: got o_R=%b want 0001", o_R);
    else n_pass++;
    i_D = 16'h0020;
    @(negedge clk);
    n_checks++;
    if (o_R !== 4'b1000) $display("FAIL strobe_0020: got o_R=%b want 1000", o_R);
    else n_pass++;
    i_D = 16'h0000;
    @(negedge clk);
    n_checks++;
    if (o_R !== 4'b0000) $display("FAIL strobe_none: got o_R=%b want 0000", o_R);
    else n_pass++;
  endtask

  task automatic test_interrupt();
    i_keys = '0; i_int_keys = '0; i_D = '0;
    apply_reset(1);
    i_int_keys = 2'b01;
    repeat (11) @(negedge clk);
    n_checks++;
    if (o_int0 !== 1'b0) $display("FAIL int0_early: got %b want 0", o_int0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_int0 !== 1'b1 || o_int1 !== 1'b0)
      $display("FAIL int0_accept: got int0=%b int1=%b want 1/0", o_int0, o_int1);
    else n_pass++;
    @(negedge clk);
    i_int_keys = 2'b00;
    repeat (10) @(negedge clk);
    n_checks++;
    if (o_int0 !== 1'b1) $display("FAIL int0_release_early: got %b want 1", o_int0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_int0 !== 1'b0 || o_int1 !== 1'b0)
      $display("FAIL int0_release: got int0=%b int1=%b want 0/0", o_int0, o_int1);
    else n_pass++;
  endtask

  task automatic test_reset_mid_debounce();
    i_keys = '0; i_int_keys = '0; i_D = '0;
    apply_reset(1);
    i_keys[5] = 1'b1;
    repeat (9) @(negedge clk);
    apply_reset(1);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_keys !== '0)
        $display("FAIL midreset_early: clk %0d got o_keys=%h want 0", i, o_keys);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (o_keys !== 64'h20)
      $display("FAIL midreset_accept: got o_keys=%h want %h", o_keys, 64'h20);
    else n_pass++;
  endtask

  task automatic test_random();
    i_keys = '0; i_int_keys = '0; i_D = '0;
    apply_reset(1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (o_keys !== m_deb[NK-1:0])
        $display("FAIL rand_keys: cyc %0d got %h want %h", cyc, o_keys, m_deb[NK-1:0]);
      else n_pass++;
      n_checks++;
      if ({o_int1, o_int0} !== m_deb[NIN-1:NK])
        $display("FAIL rand_int: cyc %0d got %b%b want %b", cyc, o_int1, o_int0, m_deb[NIN-1:NK]);
      else n_pass++;
      n_checks++;
      if (o_R !== m_R)
        $display("FAIL rand_R: cyc %0d got %b want %b", cyc, o_R, m_R);
      else n_pass++;
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 23) == 0) i_keys[k] = ~i_keys[k];
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 19) == 0) i_int_keys[k] = ~i_int_keys[k];
      case ($urandom_range(0, 3))
        0:       i_D = '0;
        1:       i_D = 16'(1) << $urandom_range(0, 15);
        2:       i_D = 16'($urandom);
        default: ;
      endcase
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_keys = '1; i_int_keys = 2'b11; i_D = 16'hFFFF;
    test_reset();
    test_clean_press();
    test_glitch();
    test_multi_strobe();
    test_interrupt();
    test_reset_mid_debounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
